// File: rtl/fifo_sync_std_if.sv
// Handshake bundle for fifo_sync_std: write port, standard read port, flags and error pulses.
// The master modport is the client side, the slave modport is the FIFO.
interface fifo_sync_std_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32
);
  logic [WIDTH-1:0]         din;
  logic                     wr_en;
  logic                     full;
  logic                     prog_full;
  logic                     overflow;
  logic                     rd_en;
  logic [WIDTH-1:0]         dout;
  logic                     dout_valid;
  logic                     empty;
  logic                     prog_empty;
  logic                     underflow;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output din, wr_en, rd_en,
    input  full, prog_full, overflow, dout, dout_valid, empty, prog_empty, underflow, count
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, prog_full, overflow, dout, dout_valid, empty, prog_empty, underflow, count
  );
endinterface

// File: rtl/fifo_sync_std.sv
// Synchronous FIFO with a registered (latency-1) read port and programmable flags.
// Flags are decoded from the occupancy register only, so they change only after an edge.
module fifo_sync_std #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned PROG_FULL  = DEPTH / 2,
  parameter int unsigned PROG_EMPTY = 2
) (
  input  logic           clk,
  input  logic           rst,
  fifo_sync_std_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             overflow_q, underflow_q;
  logic             full, empty;
  logic             wr_acc, rd_acc;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr_q] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_valid_q <= rd_acc;
      overflow_q   <= bus.wr_en && full;
      underflow_q  <= bus.rd_en && empty;
      if (wr_acc) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (rd_acc) begin
        dout_q <= mem[rptr_q];
        rptr_q <= rptr_q + AW'(1);
      end
    end
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.prog_full  = (count_q >= CW'(PROG_FULL));
  assign bus.prog_empty = (count_q <= CW'(PROG_EMPTY));
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_fifo_sync_std.sv
// Self-checking bench for fifo_sync_std: a short vector table plus scoreboarded sequences
// for fill/drain, pointer wrap, simultaneous access at the limits and asynchronous reset.
module tb_fifo_sync_std;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned PF    = DEPTH / 2;
  localparam int unsigned PE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_sync_std_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_sync_std #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .PROG_FULL  (PF),
    .PROG_EMPTY (PE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];       // model contents
  logic [WIDTH-1:0] exp_q[$];    // words expected on dout, in order
  logic [WIDTH-1:0] last_dout = '0;

  typedef struct {
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] din;
    int               cnt;
    logic             dv;
    logic [WIDTH-1:0] dout;
    logic             ovf;
    logic             udf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, update the model, then compare everything #1 after the edge.
  task automatic do_cycle(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    int   cnt;
    logic wacc, racc;
    cnt  = mq.size();
    wacc = wr && (cnt < DEPTH);
    racc = rd && (cnt > 0);
    if (racc) exp_q.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.din   = d;
    @(posedge clk);
    #1;
    check("count", int'(bus.count), mq.size());
    check("empty", int'(bus.empty), int'(mq.size() == 0));
    check("full", int'(bus.full), int'(mq.size() == DEPTH));
    check("prog_full", int'(bus.prog_full), int'(mq.size() >= PF));
    check("prog_empty", int'(bus.prog_empty), int'(mq.size() <= PE));
    check("overflow", int'(bus.overflow), int'(wr && cnt == DEPTH));
    check("underflow", int'(bus.underflow), int'(rd && cnt == 0));
    check("dout_valid", int'(bus.dout_valid), int'(racc));
    if (racc && exp_q.size() > 0) last_dout = exp_q.pop_front();
    check("dout", int'(bus.dout), int'(last_dout));
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    last_dout = '0;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0};  // idle after reset
    vecs[1] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 8'h00, 1'b0, 1'b0};  // write 0x11
    vecs[2] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h11, 1'b0, 1'b0};  // read it next edge
    vecs[3] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h11, 1'b0, 1'b0};  // dout holds
    vecs[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h11, 1'b0, 1'b1};  // read when empty
    vecs[5] = '{1'b1, 1'b1, 8'h22, 1, 1'b0, 8'h11, 1'b0, 1'b1};  // wr+rd when empty
    vecs[6] = '{1'b1, 1'b1, 8'h33, 1, 1'b1, 8'h22, 1'b0, 1'b0};  // wr+rd at count 1
    vecs[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h33, 1'b0, 1'b0};

    #23 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_count", int'(bus.count), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_prog_empty", int'(bus.prog_empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_prog_full", int'(bus.prog_full), 0);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_dout_valid", int'(bus.dout_valid), 0);

    for (int i = 0; i < 9; i++) begin
      do_cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d_count", i), int'(bus.count), vecs[i].cnt);
      check($sformatf("vec%0d_dv", i), int'(bus.dout_valid), int'(vecs[i].dv));
      check($sformatf("vec%0d_dout", i), int'(bus.dout), int'(vecs[i].dout));
      check($sformatf("vec%0d_ovf", i), int'(bus.overflow), int'(vecs[i].ovf));
      check($sformatf("vec%0d_udf", i), int'(bus.underflow), int'(vecs[i].udf));
    end

    // Fill to full, one rejected write, then drain with rd_en held.
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b1, 1'b0, WIDTH'(i));
      if (i == PF - 2) check("prog_full_below", int'(bus.prog_full), 0);
      if (i == PF - 1) check("prog_full_at", int'(bus.prog_full), 1);
    end
    check("full_at_depth", int'(bus.full), 1);
    do_cycle(1'b1, 1'b0, 8'hEE);
    check("ovf_pulse", int'(bus.overflow), 1);
    do_cycle(1'b0, 1'b0, 8'h00);
    check("ovf_one_cycle", int'(bus.overflow), 0);
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      check("drain_order", int'(bus.dout), i);
    end
    do_cycle(1'b0, 1'b1, 8'h00);
    check("dv_drop_after_empty", int'(bus.dout_valid), 0);

    // Pointer wrap-around.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'b0, WIDTH'(8'h40 + r * 20 + i));
      for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b1, 8'h00);
    end
    check("wrap_count_end", int'(bus.count), 0);

    // Simultaneous access when full: read wins, dout is the oldest word.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, WIDTH'(8'h80 + i));
    do_cycle(1'b1, 1'b1, 8'hFF);
    check("full_wr_rd_count", int'(bus.count), DEPTH - 1);
    check("full_wr_rd_dout", int'(bus.dout), 8'h80);
    check("full_wr_rd_ovf", int'(bus.overflow), 1);
    for (int i = 0; i < DEPTH - 1; i++) do_cycle(1'b0, 1'b1, 8'h00);

    // Asynchronous reset mid-drain with 10 words held.
    for (int i = 0; i < 12; i++) do_cycle(1'b1, 1'b0, WIDTH'(8'hC0 + i));
    do_cycle(1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b1, 8'h00);
    check("pre_rst_count", int'(bus.count), 10);
    #2 rst = 1'b1;
    #1;
    check("arst_count", int'(bus.count), 0);
    check("arst_empty", int'(bus.empty), 1);
    check("arst_prog_empty", int'(bus.prog_empty), 1);
    check("arst_full", int'(bus.full), 0);
    check("arst_prog_full", int'(bus.prog_full), 0);
    check("arst_dout", int'(bus.dout), 0);
    check("arst_dout_valid", int'(bus.dout_valid), 0);
    check("arst_ovf", int'(bus.overflow), 0);
    check("arst_udf", int'(bus.underflow), 0);
    bus.rd_en = 1'b0;
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(1'b1, 1'b0, 8'hA5);
    do_cycle(1'b0, 1'b1, 8'h00);
    check("post_rst_data", int'(bus.dout), 8'hA5);
    do_cycle(1'b0, 1'b1, 8'h00);
    check("post_rst_empty", int'(bus.empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_sync_std.md
Name: fifo_sync_std

Overview:
- Self-contained synchronous FIFO with a standard (non-FWFT) read port.
- rd_en requests a word; the word appears on dout one clock later, qualified by dout_valid.
- Counterpart to the FWFT wrapper on the consumer side: it serves clients that expect registered read latency 1 rather than data-ahead presentation.
- Owns its storage, pointers, occupancy count, programmable flags and error pulses.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 32, number of entries; must be a power of two, at least 2.
- PROG_FULL, DEPTH/2, prog_full asserts when count >= PROG_FULL; legal range 1..DEPTH.
- PROG_EMPTY, 2, prog_empty asserts when count <= PROG_EMPTY; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- full  out  1  count == DEPTH.
- prog_full  out  1  count >= PROG_FULL.
- overflow  out  1  one-cycle pulse: write rejected.
- rd_en  in  1  read request.
- dout  out  WIDTH  read data, registered.
- dout_valid  out  1  dout holds the word for a read accepted on the previous edge.
- empty  out  1  count == 0.
- prog_empty  out  1  count <= PROG_EMPTY.
- underflow  out  1  one-cycle pulse: read rejected.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-transfer included):
  - Pointers, count, dout, dout_valid, overflow and underflow all go to 0.
  - Flags therefore read empty=1, prog_empty=1, full=0, prog_full=0.
  - Storage array is not reset. Any in-flight read is discarded.
- Write accept = wr_en && !full. On the edge, din goes to mem[wptr] and wptr increments modulo DEPTH.
- Read accept = rd_en && !empty. On the edge, dout <= mem[rptr], rptr increments modulo DEPTH, and dout_valid <= 1.
- Without a read accept, dout_valid <= 0 and dout holds its last value. dout never changes without an accepted read.
- Count update per edge:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
  - Width clog2(DEPTH)+1 so that DEPTH is representable.
- All flags are decoded combinationally from the count register only, never from the rd_en/wr_en inputs. Flags change only after an edge.
- Pointers are clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Not FWFT: a word written on edge N is:
  - visible as empty=0 after edge N,
  - readable by rd_en sampled at edge N+1,
  - on dout with dout_valid=1 after edge N+1.
  - Minimum write-to-dout latency is 2 cycles.
- Simultaneous wr_en and rd_en:
  - Count 0: write accepted, read rejected, underflow pulses, count becomes 1.
  - Count == DEPTH: read accepted, write rejected, overflow pulses, count becomes DEPTH-1. No write-through when full.
  - 0 < count < DEPTH: both accepted, count unchanged. When count == 1, the old word is read and the new word is stored.
- Error pulses:
  - overflow <= wr_en && full, registered; high for exactly one cycle per rejected request.
  - underflow <= rd_en && empty, registered, likewise.
  - State is not otherwise altered by rejected requests.
- Back-to-back reads: rd_en held high drains one word per cycle with dout_valid continuously high. dout_valid drops the cycle after empty is sampled.

Test Plan:
- Reset then idle -> empty=1, prog_empty=1, full=0, prog_full=0, count=0, dout=0, dout_valid=0.
- Write 0x11 at edge N, pulse rd_en at edge N+1 -> after N+1: dout=0x11, dout_valid=1, count=0; one cycle later dout_valid=0 and dout stays 0x11.
- Write 32 words 0x00..0x1F (DEPTH=32) -> prog_full rises when count reaches 16, full rises at 32. A 33rd write gives overflow for 1 cycle and count stays 32. Draining returns 0x00..0x1F in order.
- Wrap-around: fill 20, read 20, fill 20, read 20 -> order preserved across the pointer wrap; count ends at 0.
- Simultaneous wr_en/rd_en when empty -> underflow pulse, count=1, dout_valid=0. Same when full -> overflow pulse, count=31, dout = oldest word.
- Assert rst asynchronously mid-drain with count=10 -> all outputs take reset values immediately, before the next clock edge. After release, a fresh write/read returns only new data.
